// File: rtl/successive_difference_ctrl.sv
// Sequencer around one successive_difference datapath: gathers an N-sample window from a
// serial stream, holds it on the datapath for DP_LATENCY cycles, captures the N results
// and streams them out with valid/ready backpressure.
module successive_difference_ctrl #(
  parameter int unsigned N          = 9,
  parameter int unsigned W          = 8,
  parameter int unsigned DP_LATENCY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [W-1:0]     m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [N*W-1:0]   dp_in,
  input  logic [N*W-1:0]   dp_out,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAT_W = ($clog2(DP_LATENCY + 1) > 0) ? $clog2(DP_LATENCY + 1) : 1;

  typedef enum logic [1:0] {StLoad, StWait, StDrain} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [N*W-1:0]     win_q, win_d;
  logic [N*W-1:0]     res_q, res_d;
  logic [CNT_W-1:0]   fc_q, fc_d;

  logic idx_at_end;
  assign idx_at_end = (idx_q == IDX_W'(N - 1));

  // Next-state: window fill, latency wait, result drain.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    win_d   = win_q;
    res_d   = res_q;
    fc_d    = fc_q;
    unique case (state_q)
      StLoad: begin
        // s_ready is constantly high here, so s_valid alone is an accept.
        if (s_valid) begin
          win_d[W*int'(idx_q) +: W] = s_data;
          if (idx_at_end) begin
            state_d = StWait;
            idx_d   = '0;
            lat_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StWait: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_W'(DP_LATENCY - 1)) begin
          res_d   = dp_out;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (m_ready) begin
          if (idx_at_end) begin
            idx_d   = '0;
            fc_d    = fc_q + 1'b1;
            state_d = StLoad;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      idx_q   <= '0;
      lat_q   <= '0;
      win_q   <= '0;
      res_q   <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      win_q   <= win_d;
      res_q   <= res_d;
      fc_q    <= fc_d;
    end
  end

  // Outputs decoded purely from registers; no path from s_valid or m_ready.
  always_comb begin
    s_ready     = (state_q == StLoad);
    busy        = (state_q != StLoad);
    m_valid     = (state_q == StDrain);
    m_last      = m_valid && idx_at_end;
    m_data      = m_valid ? res_q[W*int'(idx_q) +: W] : '0;
    dp_in       = win_q;
    frame_count = fc_q;
  end

endmodule

// File: tb/tb_successive_difference_ctrl.sv
// Bench for successive_difference_ctrl: directed table of frames, hand-written reset and
// counter-wrap sequences, and randomized frames checked against a window/difference model.
module tb_successive_difference_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid, m_ready;
  logic        sel;  // 0: default instance, 1: DP_LATENCY=3 / CNT_W=2 instance

  logic        s_ready_a, m_valid_a, m_last_a, busy_a;
  logic [7:0]  m_data_a;
  logic [71:0] dp_in_a, dp_out_a;
  logic [15:0] fc_a;

  logic        s_ready_b, m_valid_b, m_last_b, busy_b;
  logic [7:0]  m_data_b;
  logic [71:0] dp_in_b, dp_out_b;
  logic [1:0]  fc_b;

  logic        s_valid_a, s_valid_b, m_ready_a, m_ready_b;
  assign s_valid_a = s_valid & ~sel;
  assign m_ready_a = m_ready & ~sel;
  assign s_valid_b = s_valid & sel;
  assign m_ready_b = m_ready & sel;

  successive_difference_ctrl #(.N(9), .W(8), .DP_LATENCY(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .m_last(m_last_a),
    .dp_in(dp_in_a), .dp_out(dp_out_a), .busy(busy_a), .frame_count(fc_a)
  );

  successive_difference_ctrl #(.N(9), .W(8), .DP_LATENCY(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b),
    .dp_in(dp_in_b), .dp_out(dp_out_b), .busy(busy_b), .frame_count(fc_b)
  );

  // Datapath stub: out1 = in1, outk = ink - ink-1 (mod 256).
  function automatic logic [71:0] dp_f(input logic [71:0] x);
    logic [71:0] y;
    y[7:0] = x[7:0];
    for (int k = 1; k < 9; k++) y[k*8 +: 8] = x[k*8 +: 8] - x[(k-1)*8 +: 8];
    return y;
  endfunction

  // dp_out must be valid at the DP_LATENCY-th edge after dp_in settles: latency 1 is a
  // combinational stub, latency 3 delays dp_in through two register stages.
  logic [71:0] b_d1, b_d2;
  always @(posedge clk) begin
    b_d1 <= dp_in_b;
    b_d2 <= b_d1;
  end
  assign dp_out_a = dp_f(dp_in_a);
  assign dp_out_b = dp_f(b_d2);

  logic        s_ready, m_valid, m_last, busy;
  logic [7:0]  m_data;
  logic [71:0] dp_in;
  logic [15:0] fc;
  assign s_ready = sel ? s_ready_b : s_ready_a;
  assign m_valid = sel ? m_valid_b : m_valid_a;
  assign m_last  = sel ? m_last_b  : m_last_a;
  assign busy    = sel ? busy_b    : busy_a;
  assign m_data  = sel ? m_data_b  : m_data_a;
  assign dp_in   = sel ? dp_in_b   : dp_in_a;
  assign fc      = sel ? {14'd0, fc_b} : fc_a;

  int total = 0;
  int bad   = 0;
  int exp_fc = 0;

  logic [7:0] cur_smp [9];
  logic [7:0] cur_exp [9];

  typedef struct {
    logic [7:0] smp [9];
    logic [7:0] res [9];
    int         gap;
    int         mode;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int fc_mod();
    return sel ? (exp_fc % 4) : (exp_fc % 65536);
  endfunction

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_fc = 0;
  endtask

  // Runs one frame from cur_smp. gap<0: random 0..3 idle cycles between samples.
  // mode 0: m_ready=1, 1: pattern 1,0,0, 2: random. Stops after stop_beats beats; a
  // complete frame is followed by a post-frame state check.
  task automatic run_frame(input int gap, input int mode, input int lat, input int stop_beats);
    int acc = 0, beats = 0, cyc = 0, gapcnt = 0, acc_cyc = -1000;
    logic held = 1'b0;
    logic [7:0] held_d = '0;
    logic exp_busy, exp_mv;
    logic [71:0] packed_win;
    while (beats < stop_beats && cyc < 400) begin
      @(negedge clk);
      cyc++;
      exp_busy = (acc >= 9);
      exp_mv   = (acc >= 9) && ((cyc - acc_cyc) >= lat + 1);
      check("busy", busy, exp_busy);
      check("s_ready", s_ready, !exp_busy);
      check("m_valid", m_valid, exp_mv);
      if (held && m_valid) check("m_data_hold", m_data, held_d);
      s_valid = (acc < 9) && (gapcnt == 0);
      s_data  = s_valid ? cur_smp[acc] : 8'($urandom);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc % 3) == 1);
        default: m_ready = 1'($urandom);
      endcase
      if (s_valid && s_ready) begin
        acc++;
        if (acc == 9) acc_cyc = cyc;
        gapcnt = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      end else if (gapcnt > 0) begin
        gapcnt--;
      end
      if (m_valid && m_ready) begin
        check("m_data", m_data, cur_exp[beats]);
        check("m_last", m_last, beats == 8);
        beats++;
        held = 1'b0;
      end else if (m_valid) begin
        held   = 1'b1;
        held_d = m_data;
      end
    end
    if (cyc >= 400) check("frame_timeout", 72'(beats), 72'(stop_beats));
    if (stop_beats == 9) begin
      @(negedge clk);
      s_valid = 1'b0;
      m_ready = 1'b0;
      exp_fc++;
      for (int k = 0; k < 9; k++) packed_win[k*8 +: 8] = cur_smp[k];
      check("post_m_valid", m_valid, 1'b0);
      check("post_m_last", m_last, 1'b0);
      check("post_s_ready", s_ready, 1'b1);
      check("post_busy", busy, 1'b0);
      check("frame_count", fc, 72'(fc_mod()));
      check("dp_in_window", dp_in, packed_win);
    end
  endtask

  task automatic model_frame();
    for (int k = 0; k < 9; k++) cur_smp[k] = 8'($urandom);
    cur_exp[0] = cur_smp[0];
    for (int k = 1; k < 9; k++)
      cur_exp[k] = 8'((int'(cur_smp[k]) - int'(cur_smp[k-1]) + 256) % 256);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0].smp = '{8'd1, 8'd3, 8'd4, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1, 8'd1};
    vecs[0].res = '{8'd1, 8'd2, 8'd1, 8'd1, 8'd4, 8'd248, 8'd0, 8'd0, 8'd0};
    vecs[0].gap = 0; vecs[0].mode = 0;
    vecs[1] = vecs[0]; vecs[1].mode = 1;
    vecs[2] = vecs[0]; vecs[2].gap = 3;
    vecs[3].smp = '{8'd200, 8'd100, 8'd0, 8'd255, 8'd1, 8'd128, 8'd127, 8'd0, 8'd255};
    vecs[3].res = '{8'd200, 8'd156, 8'd156, 8'd255, 8'd2, 8'd127, 8'd255, 8'd129, 8'd255};
    vecs[3].gap = 1; vecs[3].mode = 1;

    sel = 1'b0;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, 8'd0);
    check("rst_dp_in", dp_in, 72'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_count", fc, 16'd0);
    rst = 1'b0;
    exp_fc = 0;

    // Directed frames: basic, backpressure, input gaps, wrap-around values.
    for (int i = 0; i < 4; i++) begin
      cur_smp = vecs[i].smp;
      cur_exp = vecs[i].res;
      run_frame(vecs[i].gap, vecs[i].mode, 1, 9);
    end

    // Reset after the 4th output beat.
    cur_smp = vecs[0].smp;
    cur_exp = vecs[0].res;
    run_frame(0, 0, 1, 4);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b1);
    check("mid_rst_frame_count", fc, 16'd0);
    check("mid_rst_dp_in", dp_in, 72'd0);
    check("mid_rst_m_data", m_data, 8'd0);
    rst = 1'b0;
    exp_fc = 0;
    for (int k = 0; k < 9; k++) begin
      cur_smp[k] = 8'((k + 1) * 10);
      cur_exp[k] = 8'd10;
    end
    run_frame(0, 0, 1, 9);

    // Randomized frames with random gaps and backpressure.
    for (int f = 0; f < 15; f++) begin
      model_frame();
      run_frame(-1, 2, 1, 9);
    end

    // DP_LATENCY=3, CNT_W=2 instance: latency, data, counter wrap 1,2,3,0,1.
    sel = 1'b1;
    do_reset();
    cur_smp = vecs[0].smp;
    cur_exp = vecs[0].res;
    run_frame(0, 0, 3, 9);
    for (int f = 0; f < 4; f++) begin
      model_frame();
      run_frame(-1, 2, 3, 9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
